openhmc_rf_arbiter: RTL and testbench

OPENHMC_RF_ARBITER -- requirements
Module: openhmc_rf_arbiter

---
 rtl/openhmc_rf_arbiter.sv | 149 ++++++++++++++
 tb/tb_openhmc_rf_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/openhmc_rf_arbiter.sv
// rtl/openhmc_rf_arbiter.sv - two-requester round-robin arbiter onto a single register-file master port
// Optional access timeout is enabled by defining OPENHMC_RF_ARB_TIMEOUT_EN.
module openhmc_rf_arbiter #(
    parameter int HMC_RF_AWIDTH = 4,
    parameter int HMC_RF_WWIDTH = 64,
    parameter int HMC_RF_RWIDTH = 64,
    parameter int TIMEOUT_LOG   = 8
) (
    input  logic                       clk_hmc,
    input  logic                       res_n_hmc,
    input  logic [1:0]                 req_valid,
    input  logic [1:0]                 req_write,
    input  logic [2*HMC_RF_AWIDTH-1:0] req_address,
    input  logic [2*HMC_RF_WWIDTH-1:0] req_wdata,
    output logic [1:0]                 req_ready,
    output logic [1:0]                 req_done,
    output logic [1:0]                 req_error,
    output logic [HMC_RF_RWIDTH-1:0]   req_rdata,
    output logic [HMC_RF_AWIDTH-1:0]   rf_address,
    output logic [HMC_RF_WWIDTH-1:0]   rf_write_data,
    output logic                       rf_read_en,
    output logic                       rf_write_en,
    input  logic [HMC_RF_RWIDTH-1:0]   rf_read_data,
    input  logic                       rf_access_complete,
    input  logic                       rf_invalid_address
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0] grant;
    logic       grant_id;
    logic       last_grant;
    logic       acc_write;
    logic       acc_id;
    logic       complete;
    logic       timeout;

    if (TIMEOUT_LOG < 2) begin : g_timeout_log_check
        $error("TIMEOUT_LOG must be at least 2");
    end

    // Grant is only offered in IDLE; with both requesting, the one not served last wins.
    always_comb begin
        grant = 2'b00;
        if (state == ST_IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign grant_id  = grant[1];

    // Responses are only meaningful while an access is outstanding.
    assign complete = ((state == ST_ISSUE) || (state == ST_WAIT)) && rf_access_complete;

`ifdef OPENHMC_RF_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_LOG-1:0] TIMEOUT_LAST = TIMEOUT_LOG'((1 << TIMEOUT_LOG) - 2);

    logic [TIMEOUT_LOG-1:0] timeout_cnt;

    // Counter holds the number of WAIT cycles already elapsed without completion.
    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            timeout_cnt <= '0;
        end else if ((state == ST_WAIT) && !rf_access_complete && !timeout) begin
            timeout_cnt <= timeout_cnt + TIMEOUT_LOG'(1);
        end else begin
            timeout_cnt <= '0;
        end
    end

    assign timeout = (state == ST_WAIT) && !rf_access_complete && (timeout_cnt == TIMEOUT_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (|grant) state_next = ST_ISSUE;
            ST_ISSUE: state_next = complete ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (complete || timeout) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign rf_read_en  = (state == ST_ISSUE) && !acc_write;
    assign rf_write_en = (state == ST_ISSUE) &&  acc_write;

    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            last_grant    <= 1'b1;
            acc_write     <= 1'b0;
            acc_id        <= 1'b0;
            rf_address    <= '0;
            rf_write_data <= '0;
            req_done      <= 2'b00;
            req_error     <= 2'b00;
            req_rdata     <= '0;
        end else begin
            req_done  <= 2'b00;
            req_error <= 2'b00;

            if (|grant) begin
                last_grant    <= grant_id;
                acc_id        <= grant_id;
                acc_write     <= req_write[grant_id];
                rf_address    <= grant_id ? req_address[HMC_RF_AWIDTH +: HMC_RF_AWIDTH]
                                          : req_address[0 +: HMC_RF_AWIDTH];
                rf_write_data <= grant_id ? req_wdata[HMC_RF_WWIDTH +: HMC_RF_WWIDTH]
                                          : req_wdata[0 +: HMC_RF_WWIDTH];
            end

            // A completion arriving on the last WAIT cycle beats the timeout.
            if (complete) begin
                req_done[acc_id]  <= 1'b1;
                req_error[acc_id] <= rf_invalid_address;
                if (!acc_write) begin
                    req_rdata <= rf_read_data;
                end
            end else if (timeout) begin
                req_done[acc_id]  <= 1'b1;
                req_error[acc_id] <= 1'b1;
                req_rdata         <= '0;
            end
        end
    end

endmodule

// File: tb/tb_openhmc_rf_arbiter.sv
// tb/tb_openhmc_rf_arbiter.sv - directed self-checking bench for openhmc_rf_arbiter
module tb_openhmc_rf_arbiter;

    logic         clk_hmc = 1'b0;
    logic         res_n_hmc;
    logic [1:0]   req_valid;
    logic [1:0]   req_write;
    logic [7:0]   req_address;
    logic [127:0] req_wdata;
    logic [1:0]   req_ready;
    logic [1:0]   req_done;
    logic [1:0]   req_error;
    logic [63:0]  req_rdata;
    logic [3:0]   rf_address;
    logic [63:0]  rf_write_data;
    logic         rf_read_en;
    logic         rf_write_en;
    logic [63:0]  rf_read_data;
    logic         rf_access_complete;
    logic         rf_invalid_address;

    int total = 0;
    int bad   = 0;

    openhmc_rf_arbiter #(
        .HMC_RF_AWIDTH(4),
        .HMC_RF_WWIDTH(64),
        .HMC_RF_RWIDTH(64),
        .TIMEOUT_LOG  (4)
    ) dut (
        .clk_hmc           (clk_hmc),
        .res_n_hmc         (res_n_hmc),
        .req_valid         (req_valid),
        .req_write         (req_write),
        .req_address       (req_address),
        .req_wdata         (req_wdata),
        .req_ready         (req_ready),
        .req_done          (req_done),
        .req_error         (req_error),
        .req_rdata         (req_rdata),
        .rf_address        (rf_address),
        .rf_write_data     (rf_write_data),
        .rf_read_en        (rf_read_en),
        .rf_write_en       (rf_write_en),
        .rf_read_data      (rf_read_data),
        .rf_access_complete(rf_access_complete),
        .rf_invalid_address(rf_invalid_address)
    );

    always #5 clk_hmc = ~clk_hmc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_hmc);
        #1;
    endtask

    always @(negedge clk_hmc) begin
        if (res_n_hmc === 1'b1) chk("rd_wr_excl", 64'(rf_read_en & rf_write_en), 64'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Single-requester access; completion is driven on cycle k after accept (cycle 0).
    task automatic run_access(input string tag, input int id, input bit wr, input logic [3:0] addr,
                              input logic [63:0] wd, input int k, input bit inv,
                              input logic [63:0] rf_rd, input logic [63:0] exp_rdata);
        logic [1:0] onehot;
        onehot = 2'b01 << id;
        req_valid = onehot;
        req_write = wr ? onehot : 2'b00;
        req_address = '0;
        req_address[id*4 +: 4] = addr;
        req_wdata = '0;
        req_wdata[id*64 +: 64] = wd;
        #2 chk({tag, "_ready"}, 64'(req_ready), 64'(onehot));
        tick();
        req_valid = 2'b00;
        for (int c = 1; c <= k; c++) begin
            if (c == k) begin
                rf_access_complete = 1'b1;
                rf_invalid_address = inv;
                rf_read_data       = rf_rd;
            end
            #2;
            chk({tag, "_rd_en"}, 64'(rf_read_en), (c == 1 && !wr) ? 64'd1 : 64'd0);
            chk({tag, "_wr_en"}, 64'(rf_write_en), (c == 1 && wr) ? 64'd1 : 64'd0);
            chk({tag, "_addr"}, 64'(rf_address), 64'(addr));
            chk({tag, "_no_done"}, 64'(req_done), 64'd0);
            if (c == 1) chk({tag, "_wdata"}, rf_write_data, wd);
            tick();
        end
        rf_access_complete = 1'b0;
        rf_invalid_address = 1'b0;
        rf_read_data       = 64'h0;
        #2;
        chk({tag, "_done"}, 64'(req_done), 64'(onehot));
        chk({tag, "_error"}, 64'(req_error), inv ? 64'(onehot) : 64'd0);
        chk({tag, "_rdata"}, req_rdata, exp_rdata);
        tick();
        #2;
        chk({tag, "_done_clr"}, 64'(req_done), 64'd0);
        chk({tag, "_error_clr"}, 64'(req_error), 64'd0);
    endtask

    initial begin
        res_n_hmc          = 1'b0;
        req_valid          = 2'b00;
        req_write          = 2'b00;
        req_address        = '0;
        req_wdata          = '0;
        rf_read_data       = '0;
        rf_access_complete = 1'b0;
        rf_invalid_address = 1'b0;
        repeat (3) tick();
        #2;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_done", 64'(req_done), 64'd0);
        chk("rst_error", 64'(req_error), 64'd0);
        chk("rst_rdata", req_rdata, 64'd0);
        chk("rst_rd_en", 64'(rf_read_en), 64'd0);
        chk("rst_wr_en", 64'(rf_write_en), 64'd0);
        chk("rst_addr", 64'(rf_address), 64'd0);
        chk("rst_wdata", rf_write_data, 64'd0);
        tick();
        res_n_hmc = 1'b1;
        tick();

        run_access("rd0", 0, 1'b0, 4'h3, 64'h0, 3, 1'b0, 64'hDEAD, 64'hDEAD);
        run_access("wr1_inv", 1, 1'b1, 4'hF, 64'h1234_5678_9ABC_DEF0, 2, 1'b1, 64'hBEEF, 64'hDEAD);

        // Both requesters valid throughout: grants alternate starting with requester 0.
        req_valid   = 2'b11;
        req_write   = 2'b10;
        req_address = {4'hA, 4'h5};
        req_wdata   = {64'hAAAA, 64'h5555};
        for (int i = 0; i < 4; i++) begin
            logic [1:0] exp_g;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            #2 chk($sformatf("rr%0d_ready", i), 64'(req_ready), 64'(exp_g));
            tick();
            rf_access_complete = 1'b1;
            rf_read_data = 64'h100 + 64'(i);
            #2;
            chk($sformatf("rr%0d_en", i), 64'({rf_write_en, rf_read_en}), 64'(exp_g));
            chk($sformatf("rr%0d_addr", i), 64'(rf_address), (i % 2 == 0) ? 64'h5 : 64'hA);
            chk($sformatf("rr%0d_busy", i), 64'(req_ready), 64'd0);
            tick();
            rf_access_complete = 1'b0;
            #2 chk($sformatf("rr%0d_done", i), 64'(req_done), 64'(exp_g));
        end
        chk("rr_rdata", req_rdata, 64'h102);
        req_valid = 2'b00;
        req_write = 2'b00;
        tick();

        // Reset during WAIT; a late completion afterwards must be ignored.
        req_valid = 2'b01;
        req_address = {4'h0, 4'h7};
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        res_n_hmc = 1'b0;
        #2;
        chk("mid_rst_addr", 64'(rf_address), 64'd0);
        chk("mid_rst_done", 64'(req_done), 64'd0);
        tick();
        res_n_hmc = 1'b1;
        rf_access_complete = 1'b1;
        rf_read_data = 64'hBAD;
        #2 chk("late_rd_en", 64'(rf_read_en), 64'd0);
        tick();
        rf_access_complete = 1'b0;
        #2;
        chk("late_done", 64'(req_done), 64'd0);
        chk("late_error", 64'(req_error), 64'd0);
        chk("late_rdata", req_rdata, 64'd0);
        req_valid = 2'b11;
        #2 chk("post_rst_grant", 64'(req_ready), 64'd1);
        req_valid = 2'b00;
        tick();

`ifdef OPENHMC_RF_ARB_TIMEOUT_EN
        req_valid = 2'b01;
        req_write = 2'b00;
        req_address = {4'h0, 4'h2};
        #2 chk("to_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        for (int c = 1; c <= 16; c++) begin
            #2 chk($sformatf("to_wait%0d", c), 64'(req_done), 64'd0);
            tick();
        end
        #2;
        chk("to_done", 64'(req_done), 64'd1);
        chk("to_error", 64'(req_error), 64'd1);
        chk("to_rdata", req_rdata, 64'd0);
        tick();
        #2 chk("to_done_clr", 64'(req_done), 64'd0);
        run_access("to_edge", 0, 1'b0, 4'h2, 64'h0, 16, 1'b0, 64'hCAFE, 64'hCAFE);
`else
        run_access("long_wait", 0, 1'b0, 4'h2, 64'h0, 40, 1'b0, 64'hCAFE, 64'hCAFE);
`endif

        run_access("final_wr0", 0, 1'b1, 4'h9, 64'h0F0F, 1, 1'b0, 64'h7777, 64'hCAFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
